// File: rtl/ripple_cnt_monitor_if.sv
// Signal bundle between the ripple-counter monitor and the counter/control side.
// The master side drives the counter sample and controls; the slave is the monitor.
interface ripple_cnt_monitor_if #(
    parameter int unsigned reg_size = 4,
    parameter int unsigned CNT_W    = 8
);
    logic [reg_size-1:0] q_in;
    logic                enable;
    logic [reg_size-1:0] cmp_val;
    logic [reg_size-1:0] preset_val;
    logic                auto_reload;
    logic                soft_load;
    logic [reg_size-1:0] p_out;
    logic                load_out;
    logic                cnt_en_out;
    logic [reg_size-1:0] q_stable;
    logic                stable_valid;
    logic                match_pulse;
    logic [CNT_W-1:0]    match_count;
    logic                err_timeout;

    modport master (
        output q_in, enable, cmp_val, preset_val, auto_reload, soft_load,
        input  p_out, load_out, cnt_en_out, q_stable, stable_valid, match_pulse,
               match_count, err_timeout
    );

    modport slave (
        input  q_in, enable, cmp_val, preset_val, auto_reload, soft_load,
        output p_out, load_out, cnt_en_out, q_stable, stable_valid, match_pulse,
               match_count, err_timeout
    );
endinterface

// File: rtl/ripple_cnt_monitor.sv
// Samples an asynchronous ripple-counter bus, qualifies stable values, detects compare
// matches and drives the counter's preset/load/enable for divide-by-N auto-reload.
module ripple_cnt_monitor #(
    parameter int unsigned reg_size      = 4,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned LOAD_CYCLES   = 2,
    parameter int unsigned SETTLE_TO     = 15,
    parameter int unsigned CNT_W         = 8
) (
    input logic                 clk,
    input logic                 rst,
    ripple_cnt_monitor_if.slave bus
);
    localparam int unsigned EqW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned LdW = $clog2(LOAD_CYCLES + 1);
    localparam int unsigned StW = $clog2(SETTLE_TO + 1);
    localparam logic [EqW-1:0] EqMax      = EqW'(STABLE_CYCLES);
    localparam logic [EqW-1:0] EqAcc      = EqW'(STABLE_CYCLES - 1);
    localparam logic [LdW-1:0] LoadLast   = LdW'(LOAD_CYCLES - 1);
    localparam logic [StW-1:0] SettleLast = StW'(SETTLE_TO - 1);

    typedef enum logic [1:0] {StIdle, StTrack, StLoad, StSettle} state_e;

    state_e              state_q, state_d;
    logic [reg_size-1:0] s1_q, s2_q;
    logic [EqW-1:0]      eq_cnt_q, eq_cnt_d;
    logic [reg_size-1:0] q_stable_q;
    logic                stable_valid_q;
    logic [LdW-1:0]      load_cnt_q, load_cnt_d;
    logic [StW-1:0]      settle_cnt_q, settle_cnt_d;
    logic [reg_size-1:0] p_out_q, p_out_d;
    logic                match_pulse_q, match_pulse_d;
    logic [CNT_W-1:0]    match_count_q, match_count_d;
    logic                err_q, err_d;
    logic                same, accept, new_event, hit;

    // Acceptance fires on the edge where eq_cnt reaches STABLE_CYCLES and keeps
    // firing while the bus stays put; only value changes count as new events.
    assign same      = (s1_q == s2_q);
    assign accept    = same && (eq_cnt_q >= EqAcc);
    assign new_event = accept && (!stable_valid_q || (s2_q != q_stable_q));
    assign hit       = new_event && (s2_q == bus.cmp_val);
    assign eq_cnt_d  = !same ? '0 : ((eq_cnt_q == EqMax) ? EqMax : eq_cnt_q + 1'b1);

    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        settle_cnt_d  = settle_cnt_q;
        p_out_d       = p_out_q;
        err_d         = err_q;
        match_pulse_d = 1'b0;
        match_count_d = match_count_q;
        unique case (state_q)
            StIdle: begin
                if (bus.enable) state_d = StTrack;
            end
            StTrack: begin
                if (hit) begin
                    match_pulse_d = 1'b1;
                    if (match_count_q != '1) match_count_d = match_count_q + 1'b1;
                end
                if (!bus.enable) begin
                    state_d = StIdle;
                end else if (bus.soft_load || (hit && bus.auto_reload)) begin
                    state_d    = StLoad;
                    p_out_d    = bus.preset_val;
                    load_cnt_d = '0;
                end
            end
            StLoad: begin
                if (load_cnt_q == LoadLast) begin
                    state_d      = StSettle;
                    settle_cnt_d = '0;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            StSettle: begin
                if ((accept && (s2_q == p_out_q)) || (settle_cnt_q == SettleLast)) begin
                    if (!(accept && (s2_q == p_out_q))) err_d = 1'b1;
                    state_d = bus.enable ? StTrack : StIdle;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            s1_q           <= '0;
            s2_q           <= '0;
            eq_cnt_q       <= '0;
            q_stable_q     <= '0;
            stable_valid_q <= 1'b0;
            load_cnt_q     <= '0;
            settle_cnt_q   <= '0;
            p_out_q        <= '0;
            match_pulse_q  <= 1'b0;
            match_count_q  <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= bus.q_in;
            s2_q          <= s1_q;
            eq_cnt_q      <= eq_cnt_d;
            load_cnt_q    <= load_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            p_out_q       <= p_out_d;
            match_pulse_q <= match_pulse_d;
            match_count_q <= match_count_d;
            err_q         <= err_d;
            if (accept) begin
                q_stable_q     <= s2_q;
                stable_valid_q <= 1'b1;
            end
        end
    end

    assign bus.p_out        = p_out_q;
    assign bus.load_out     = (state_q == StLoad);
    assign bus.cnt_en_out   = (state_q == StTrack);
    assign bus.q_stable     = q_stable_q;
    assign bus.stable_valid = stable_valid_q;
    assign bus.match_pulse  = match_pulse_q;
    assign bus.match_count  = match_count_q;
    assign bus.err_timeout  = err_q;
endmodule

// File: tb/tb_ripple_cnt_monitor.sv
// Directed bench for ripple_cnt_monitor: a behavioural ripple counter closes the
// reload loop; a second instance with a 2-bit match counter exercises saturation.
module tb_ripple_cnt_monitor;
    logic       clk = 1'b0;
    logic       rst;
    logic       model_on;
    logic [3:0] q_man;
    logic [3:0] cq;
    logic [2:0] div;
    int         checks = 0;
    int         errors = 0;
    bit         ok;

    always #5 clk = ~clk;

    ripple_cnt_monitor_if #(.reg_size(4), .CNT_W(8)) bus ();
    ripple_cnt_monitor_if #(.reg_size(4), .CNT_W(2)) bus2 ();

    ripple_cnt_monitor #(.reg_size(4), .STABLE_CYCLES(2), .LOAD_CYCLES(2),
                         .SETTLE_TO(15), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ripple_cnt_monitor #(.reg_size(4), .STABLE_CYCLES(2), .LOAD_CYCLES(2),
                         .SETTLE_TO(15), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    assign bus.q_in         = model_on ? cq : q_man;
    assign bus2.q_in        = bus.q_in;
    assign bus2.enable      = bus.enable;
    assign bus2.cmp_val     = bus.cmp_val;
    assign bus2.preset_val  = bus.preset_val;
    assign bus2.auto_reload = bus.auto_reload;
    assign bus2.soft_load   = bus.soft_load;

    // Presettable counter: loads while load is high, else steps every 6 clocks.
    always @(posedge clk) begin
        if (rst) begin
            cq  <= 4'd0;
            div <= 3'd0;
        end else begin
            div <= (div == 3'd5) ? 3'd0 : div + 3'd1;
            if (bus.load_out) cq <= bus.p_out;
            else if (bus.cnt_en_out && (div == 3'd5)) cq <= cq + 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input int maxc, output bit found);
        found = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.match_pulse === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_en(input int maxc, output bit found);
        found = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.cnt_en_out === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        model_on        = 1'b0;
        q_man           = 4'hA;
        bus.enable      = 1'b0;
        bus.cmp_val     = 4'h0;
        bus.preset_val  = 4'h0;
        bus.auto_reload = 1'b0;
        bus.soft_load   = 1'b0;

        // T1 reset
        repeat (3) @(negedge clk);
        chk("rst_q_stable", bus.q_stable, 0);
        chk("rst_valid", bus.stable_valid, 0);
        chk("rst_load", bus.load_out, 0);
        chk("rst_cnt_en", bus.cnt_en_out, 0);
        chk("rst_pulse", bus.match_pulse, 0);
        chk("rst_count", bus.match_count, 0);
        chk("rst_err", bus.err_timeout, 0);
        chk("rst_p_out", bus.p_out, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_not_yet", bus.stable_valid, 0);
        @(negedge clk);
        chk("t1_q_stable", bus.q_stable, 4'hA);
        chk("t1_valid", bus.stable_valid, 1);

        // T2 glitching bus never qualifies
        for (int i = 0; i < 10; i++) begin
            q_man = (i % 2 == 0) ? 4'h8 : 4'h7;
            @(negedge clk);
        end
        chk("t2_glitch_hold", bus.q_stable, 4'hA);
        q_man = 4'h8;
        repeat (3) @(negedge clk);
        chk("t2_not_yet", bus.q_stable, 4'hA);
        @(negedge clk);
        chk("t2_q_stable", bus.q_stable, 4'h8);
        chk("t2_idle_en", bus.cnt_en_out, 0);

        // T3 divide-by-N loop
        bus.cmp_val     = 4'h9;
        bus.preset_val  = 4'h3;
        bus.auto_reload = 1'b1;
        model_on        = 1'b1;
        bus.enable      = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_pulse(200, ok);
            chk("t3_pulse_seen", ok, 1);
            chk("t3_q_match", bus.q_stable, 4'h9);
            chk("t3_count", bus.match_count, k + 1);
            chk("t3_load1", bus.load_out, 1);
            chk("t3_p_out", bus.p_out, 4'h3);
            @(negedge clk);
            chk("t3_pulse_one", bus.match_pulse, 0);
            chk("t3_load2", bus.load_out, 1);
            @(negedge clk);
            chk("t3_load_end", bus.load_out, 0);
            chk("t3_settle_en", bus.cnt_en_out, 0);
            wait_en(30, ok);
            chk("t3_resume", ok, 1);
            chk("t3_reloaded", bus.q_stable, 4'h3);
        end
        chk("t3_count5", bus.match_count, 5);
        chk("t6_sat_count", bus2.match_count, 3);
        chk("t3_no_err", bus.err_timeout, 0);

        // T4 manual reload
        bus.auto_reload = 1'b0;
        model_on        = 1'b0;
        q_man           = 4'h5;
        repeat (6) @(negedge clk);
        chk("t4_q5", bus.q_stable, 4'h5);
        chk("t4_track", bus.cnt_en_out, 1);
        bus.preset_val = 4'hC;
        bus.soft_load  = 1'b1;
        @(negedge clk);
        bus.soft_load = 1'b0;
        chk("t4_load", bus.load_out, 1);
        chk("t4_p_out", bus.p_out, 4'hC);
        chk("t4_no_pulse", bus.match_pulse, 0);
        q_man = 4'hC;
        wait_en(30, ok);
        chk("t4_resume", ok, 1);
        chk("t4_q_c", bus.q_stable, 4'hC);
        chk("t4_count", bus.match_count, 5);
        chk("t4_no_err", bus.err_timeout, 0);

        // T6 enable dropped mid-LOAD still completes, then IDLE
        bus.preset_val = 4'h6;
        bus.soft_load  = 1'b1;
        @(negedge clk);
        bus.soft_load = 1'b0;
        chk("t6_load", bus.load_out, 1);
        bus.enable = 1'b0;
        q_man      = 4'h6;
        @(negedge clk);
        chk("t6_load_held", bus.load_out, 1);
        @(negedge clk);
        chk("t6_load_end", bus.load_out, 0);
        chk("t6_settle_en", bus.cnt_en_out, 0);
        repeat (20) @(negedge clk);
        chk("t6_no_err", bus.err_timeout, 0);
        chk("t6_idle", bus.cnt_en_out, 0);
        chk("t6_q6", bus.q_stable, 4'h6);
        bus.soft_load = 1'b1;
        @(negedge clk);
        bus.soft_load = 1'b0;
        chk("t6_drop_soft", bus.load_out, 0);
        @(negedge clk);
        chk("t6_drop_soft2", bus.load_out, 0);
        bus.enable = 1'b1;
        @(negedge clk);
        chk("t6_track", bus.cnt_en_out, 1);

        // T5 counter ignores load -> settle timeout
        bus.preset_val = 4'h2;
        bus.soft_load  = 1'b1;
        @(negedge clk);
        bus.soft_load = 1'b0;
        chk("t5_load", bus.load_out, 1);
        repeat (16) @(negedge clk);
        chk("t5_err_pre", bus.err_timeout, 0);
        chk("t5_settle", bus.cnt_en_out, 0);
        @(negedge clk);
        chk("t5_err", bus.err_timeout, 1);
        chk("t5_track", bus.cnt_en_out, 1);
        chk("t5_p_out", bus.p_out, 4'h2);
        repeat (10) @(negedge clk);
        chk("t5_sticky", bus.err_timeout, 1);

        // Reset clears everything including the sticky error
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("end_err", bus.err_timeout, 0);
        chk("end_count", bus.match_count, 0);
        chk("end_count2", bus2.match_count, 0);
        chk("end_valid", bus.stable_valid, 0);
        chk("end_cnt_en", bus.cnt_en_out, 0);
        chk("end_p_out", bus.p_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
